// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared widths, FSM state type and helpers for the rename allocation controller.
// Tag width follows the physical register file size.
package rename_alloc_ctrl_pkg;
  localparam int N        = 4;
  localparam int PR_COUNT = 64;
  localparam int PHYS_TAG = $clog2(PR_COUNT);
  localparam int CNT_W    = $clog2(N + 1);
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

  typedef logic [PHYS_TAG-1:0] phys_tag_t;

  typedef enum logic {ALLOC_RUN, ALLOC_WAIT} alloc_state_e;

  // Low-order thermometer mask with cnt bits set.
  function automatic logic [N-1:0] low_mask(input logic [CNT_W-1:0] cnt);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (CNT_W'(i) < cnt);
    return m;
  endfunction
endpackage

// File: rtl/rename_alloc_ctrl_if.sv
// Decode-side bundle handshake, freelist/ROB availability and grant outputs.
// slave = allocation controller, master = decode/freelist environment.
interface rename_alloc_ctrl_if;
  import rename_alloc_ctrl_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0]                in_lane_valid;
  logic [N-1:0]                in_dest_mask;
  logic [N-1:0][PHYS_TAG-1:0]  FreeReg;
  logic [CNT_W-1:0]            FreeSlotsForN;
  logic [CNT_W-1:0]            rob_slots;
  logic                        BPRecoverEN;
  logic [N-1:0]                AllocReqMask;
  logic [N-1:0]                out_lane_valid;
  logic [N-1:0][PHYS_TAG-1:0]  out_tag;
  logic                        alloc_stall;
  logic                        stall_alarm;

  modport slave (
    input  in_valid, in_lane_valid, in_dest_mask, FreeReg, FreeSlotsForN, rob_slots, BPRecoverEN,
    output in_ready, AllocReqMask, out_lane_valid, out_tag, alloc_stall, stall_alarm
  );

  modport master (
    output in_valid, in_lane_valid, in_dest_mask, FreeReg, FreeSlotsForN, rob_slots, BPRecoverEN,
    input  in_ready, AllocReqMask, out_lane_valid, out_tag, alloc_stall, stall_alarm
  );
endinterface

// File: rtl/rename_alloc_ctrl_prefix_grant.sv
// In-order lane grant: stops at the first pending lane that lacks a ROB slot or a free tag.
// Purely combinational; tag_idx is the freelist slot index for each granted dest lane.
module alloc_prefix_grant
  import rename_alloc_ctrl_pkg::*;
(
  input  logic [N-1:0]            pend_valid_i,
  input  logic [N-1:0]            pend_dest_i,
  input  logic [CNT_W-1:0]        free_slots_i,
  input  logic [CNT_W-1:0]        rob_slots_i,
  input  logic                    enable_i,
  output logic [N-1:0]            grant_o,
  output logic [N-1:0][IDX_W-1:0] tag_idx_o,
  output logic [CNT_W-1:0]        dest_cnt_o
);
  logic             blocked;
  logic [CNT_W-1:0] total;

  always_comb begin
    grant_o    = '0;
    tag_idx_o  = '0;
    dest_cnt_o = '0;
    blocked    = 1'b0;
    total      = '0;
    for (int i = 0; i < N; i++) begin
      if (enable_i && pend_valid_i[i] && !blocked) begin
        if ((total < rob_slots_i) && (!pend_dest_i[i] || (dest_cnt_o < free_slots_i))) begin
          grant_o[i]   = 1'b1;
          tag_idx_o[i] = dest_cnt_o[IDX_W-1:0];
          total        = total + 1'b1;
          if (pend_dest_i[i]) dest_cnt_o = dest_cnt_o + 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rename_alloc_ctrl.sv
// Holds one decode bundle and releases its lanes in order as tags and ROB slots allow,
// with a recovery blackout window and a saturating starvation counter.
module rename_alloc_ctrl
  import rename_alloc_ctrl_pkg::*;
#(
  parameter int RECOVER_WAIT = 1,
  parameter int STALL_LIMIT  = 16
) (
  input logic               clock,
  input logic               reset,
  rename_alloc_ctrl_if.slave bus
);
  localparam int WAIT_W  = $clog2(RECOVER_WAIT + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  alloc_state_e         state_q, state_d;
  logic [N-1:0]         pend_valid_q, pend_valid_d;
  logic [N-1:0]         pend_dest_q, pend_dest_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic                 grant_en;
  logic [N-1:0]         grant;
  logic [N-1:0][IDX_W-1:0] tag_idx;
  logic [CNT_W-1:0]     dest_cnt;
  logic                 accept;

  assign grant_en = (state_q == ALLOC_RUN) && !bus.BPRecoverEN;

  alloc_prefix_grant u_grant (
    .pend_valid_i (pend_valid_q),
    .pend_dest_i  (pend_dest_q),
    .free_slots_i (bus.FreeSlotsForN),
    .rob_slots_i  (bus.rob_slots),
    .enable_i     (grant_en),
    .grant_o      (grant),
    .tag_idx_o    (tag_idx),
    .dest_cnt_o   (dest_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ALLOC_RUN;
      pend_valid_q <= '0;
      pend_dest_q  <= '0;
      wait_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_dest_q  <= pend_dest_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_dest_d  = pend_dest_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    bus.in_ready       = (state_q == ALLOC_RUN) && (pend_valid_q == '0) && !bus.BPRecoverEN;
    bus.out_lane_valid = grant;
    bus.AllocReqMask   = low_mask(dest_cnt);
    bus.alloc_stall    = (pend_valid_q != '0) && (grant == '0);
    bus.stall_alarm    = (stall_cnt_q >= STALL_W'(STALL_LIMIT));
    bus.out_tag        = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i] && pend_dest_q[i]) bus.out_tag[i] = bus.FreeReg[tag_idx[i]];
    end

    accept = bus.in_valid && bus.in_ready;

    if (bus.BPRecoverEN) begin
      // Recovery wins everywhere; a reload in WAIT restarts the blackout.
      state_d      = ALLOC_WAIT;
      pend_valid_d = '0;
      pend_dest_d  = '0;
      wait_cnt_d   = WAIT_W'(RECOVER_WAIT);
      stall_cnt_d  = '0;
    end else begin
      case (state_q)
        ALLOC_RUN: begin
          pend_valid_d = pend_valid_q & ~grant;
          pend_dest_d  = pend_dest_q & ~grant;
          if (accept) begin
            pend_valid_d = bus.in_lane_valid;
            pend_dest_d  = bus.in_dest_mask & bus.in_lane_valid;
          end
          if (grant != '0) stall_cnt_d = '0;
          else if (bus.alloc_stall && (stall_cnt_q < STALL_W'(STALL_LIMIT)))
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        ALLOC_WAIT: begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q <= WAIT_W'(1)) state_d = ALLOC_RUN;
        end
        default: state_d = ALLOC_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl with hand-computed expected grants, tags and masks.
module tb_rename_alloc_ctrl;
  import rename_alloc_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  rename_alloc_ctrl_if bus ();

  rename_alloc_ctrl #(.RECOVER_WAIT(2), .STALL_LIMIT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and leave inputs settled 1 time unit past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bundle(input logic v, input logic [N-1:0] lanes, input logic [N-1:0] dest);
    bus.in_valid      = v;
    bus.in_lane_valid = lanes;
    bus.in_dest_mask  = dest;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_bundle(1'b0, '0, '0);
    bus.FreeReg       = {6'd13, 6'd12, 6'd11, 6'd10};
    bus.FreeSlotsForN = 3'd4;
    bus.rob_slots     = 3'd4;
    bus.BPRecoverEN   = 1'b0;
    #12;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_lane_valid", 64'(bus.out_lane_valid), 64'd0);
    check_eq("rst_mask", 64'(bus.AllocReqMask), 64'd0);
    check_eq("rst_stall", 64'(bus.alloc_stall), 64'd0);
    check_eq("rst_alarm", 64'(bus.stall_alarm), 64'd0);
    reset = 1'b0;

    // 1: full bundle in one cycle
    tick();
    drive_bundle(1'b1, 4'b1111, 4'b1011);
    #1 check_eq("t1_accept_ready", 64'(bus.in_ready), 64'd1);
    check_eq("t1_no_bypass", 64'(bus.out_lane_valid), 64'd0);
    tick();
    drive_bundle(1'b0, '0, '0);
    #1 check_eq("t1_grant", 64'(bus.out_lane_valid), 64'b1111);
    check_eq("t1_mask", 64'(bus.AllocReqMask), 64'b0111);
    check_eq("t1_tags", 64'(bus.out_tag), 64'({6'd12, 6'd0, 6'd11, 6'd10}));
    check_eq("t1_busy", 64'(bus.in_ready), 64'd0);
    tick();
    #1 check_eq("t1_ready_again", 64'(bus.in_ready), 64'd1);
    check_eq("t1_idle", 64'(bus.out_lane_valid), 64'd0);

    // 2: one free tag, then plenty
    drive_bundle(1'b1, 4'b1111, 4'b1011);
    bus.FreeSlotsForN = 3'd1;
    tick();
    drive_bundle(1'b0, '0, '0);
    #1 check_eq("t2_grant_a", 64'(bus.out_lane_valid), 64'b0001);
    check_eq("t2_mask_a", 64'(bus.AllocReqMask), 64'b0001);
    check_eq("t2_tag_a", 64'(bus.out_tag), 64'({6'd0, 6'd0, 6'd0, 6'd10}));
    tick();
    bus.FreeSlotsForN = 3'd4;
    #1 check_eq("t2_grant_b", 64'(bus.out_lane_valid), 64'b1110);
    check_eq("t2_mask_b", 64'(bus.AllocReqMask), 64'b0011);
    check_eq("t2_tag_b", 64'(bus.out_tag), 64'({6'd11, 6'd0, 6'd10, 6'd0}));
    tick();
    #1 check_eq("t2_ready", 64'(bus.in_ready), 64'd1);

    // 3: ROB-limited
    drive_bundle(1'b1, 4'b1111, 4'b1111);
    bus.rob_slots = 3'd2;
    tick();
    drive_bundle(1'b0, '0, '0);
    #1 check_eq("t3_grant_a", 64'(bus.out_lane_valid), 64'b0011);
    check_eq("t3_mask_a", 64'(bus.AllocReqMask), 64'b0011);
    tick();
    #1 check_eq("t3_grant_b", 64'(bus.out_lane_valid), 64'b1100);
    check_eq("t3_mask_b", 64'(bus.AllocReqMask), 64'b0011);
    check_eq("t3_tag_b", 64'(bus.out_tag), 64'({6'd11, 6'd10, 6'd0, 6'd0}));
    bus.rob_slots = 3'd4;
    tick();

    // 4: recovery with pending lanes
    drive_bundle(1'b1, 4'b0111, 4'b0111);
    bus.FreeSlotsForN = 3'd0;
    tick();
    drive_bundle(1'b0, '0, '0);
    #1 check_eq("t4_stall", 64'(bus.alloc_stall), 64'd1);
    tick();
    bus.BPRecoverEN   = 1'b1;
    bus.FreeSlotsForN = 3'd4;
    #1 check_eq("t4_pulse_ready", 64'(bus.in_ready), 64'd0);
    check_eq("t4_pulse_mask", 64'(bus.AllocReqMask), 64'd0);
    check_eq("t4_pulse_grant", 64'(bus.out_lane_valid), 64'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      bus.BPRecoverEN = 1'b0;
      #1 check_eq("t4_wait_ready", 64'(bus.in_ready), 64'd0);
      check_eq("t4_wait_mask", 64'(bus.AllocReqMask), 64'd0);
    end
    tick();
    #1 check_eq("t4_run_ready", 64'(bus.in_ready), 64'd1);
    check_eq("t4_pend_cleared", 64'(bus.out_lane_valid), 64'd0);

    // 5: starvation alarm
    drive_bundle(1'b1, 4'b0001, 4'b0001);
    bus.FreeSlotsForN = 3'd0;
    tick();
    drive_bundle(1'b0, '0, '0);
    for (int c = 1; c <= 20; c++) begin
      #1 check_eq("t5_stall", 64'(bus.alloc_stall), 64'd1);
      check_eq("t5_alarm", 64'(bus.stall_alarm), 64'(c >= 17));
      check_eq("t5_mask", 64'(bus.AllocReqMask), 64'd0);
      tick();
    end
    bus.FreeSlotsForN = 3'd1;
    #1 check_eq("t5_grant", 64'(bus.out_lane_valid), 64'b0001);
    check_eq("t5_alarm_held", 64'(bus.stall_alarm), 64'd1);
    tick();
    #1 check_eq("t5_alarm_clear", 64'(bus.stall_alarm), 64'd0);
    check_eq("t5_stall_clear", 64'(bus.alloc_stall), 64'd0);

    // 6: bundle offered during recovery is dropped
    bus.FreeSlotsForN = 3'd4;
    drive_bundle(1'b1, 4'b1111, 4'b1111);
    bus.BPRecoverEN = 1'b1;
    #1 check_eq("t6_not_ready", 64'(bus.in_ready), 64'd0);
    tick();
    drive_bundle(1'b0, '0, '0);
    bus.BPRecoverEN = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 check_eq("t6_no_grant", 64'(bus.out_lane_valid), 64'd0);
      check_eq("t6_no_pop", 64'(bus.AllocReqMask), 64'd0);
      tick();
    end
    #1 check_eq("t6_ready", 64'(bus.in_ready), 64'd1);

    // async reset with a bundle pending
    drive_bundle(1'b1, 4'b1111, 4'b1111);
    bus.FreeSlotsForN = 3'd0;
    tick();
    drive_bundle(1'b0, '0, '0);
    #2 reset = 1'b1;
    #1 check_eq("ar_ready", 64'(bus.in_ready), 64'd1);
    check_eq("ar_stall", 64'(bus.alloc_stall), 64'd0);
    bus.FreeSlotsForN = 3'd4;
    #1 check_eq("ar_no_pop", 64'(bus.AllocReqMask), 64'd0);
    reset = 1'b0;
    tick();
    #1 check_eq("ar_no_grant", 64'(bus.out_lane_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
